// File: rtl/dehaze_transmittance_est_if.sv
// Pixel stream into and out of the transmittance estimator.
// The master side drives dark/syncs; the slave side returns transmittance and delayed syncs.
interface dehaze_transmittance_est_if #(
  parameter int DW = 8
);
  logic [DW-1:0] i_dark;
  logic          i_hsync;
  logic          i_vsync;
  logic          i_de;
  logic [DW-1:0] o_transmittance;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;

  modport master (
    output i_dark, i_hsync, i_vsync, i_de,
    input  o_transmittance, o_hsync, o_vsync, o_de
  );

  modport slave (
    input  i_dark, i_hsync, i_vsync, i_de,
    output o_transmittance, o_hsync, o_vsync, o_de
  );
endinterface

// File: rtl/dehaze_transmittance_est.sv
// Per-pixel transmittance t = 1 - omega*dark/A, with A = previous frame's dark maximum.
// The reciprocal of A is computed serially during vblank and committed atomically.
//
// state | meaning
// IDLE  | active A / 1/A / omega in use, no division pending
// DIV   | restoring division of (2^(DW+FRAC)-1) by a_next, one quotient bit per cycle
// LOAD  | commit a_next, recip, omega_next to the active set
module dehaze_transmittance_est #(
  parameter int DW   = 8,
  parameter int FRAC = 16
) (
  input  logic                         pixelclk,
  input  logic                         reset_n,
  dehaze_transmittance_est_if.slave    pix,
  input  logic [7:0]                   i_omega,
  input  logic [DW-1:0]                i_a_min,
  input  logic [DW-1:0]                i_thre,
  output logic [DW-1:0]                o_atmos,
  output logic                         o_recip_busy
);
  localparam int RW = DW + FRAC;
  localparam int PW = DW + 8;
  localparam int MW = PW + RW;
  localparam int CW = $clog2(RW + 1);
  localparam logic [DW-1:0] DMAX = '1;

  typedef enum logic [1:0] {IDLE, DIV, LOAD} div_state_t;

  div_state_t    state;
  logic          vsync_q;
  logic          busy;
  logic [DW-1:0] frame_max;
  logic [DW-1:0] a_next;
  logic [DW-1:0] a_act;
  logic [7:0]    omega_next;
  logic [7:0]    omega_act;
  logic [RW-1:0] recip;
  logic [RW-1:0] recip_act;
  logic [DW-1:0] rem;
  logic [CW-1:0] div_cnt;

  logic          frame_edge;
  logic [DW-1:0] a_cand;
  logic [DW:0]   rem_shift;
  logic          rem_ge;
  logic [DW-1:0] rem_diff;

  assign frame_edge = pix.i_vsync & ~vsync_q;

  always_comb begin
    a_cand = (frame_max > i_a_min) ? frame_max : i_a_min;
    if (a_cand == '0) a_cand = DW'(1);
  end

  // The dividend is all ones, so every restoring step shifts in a 1.
  assign rem_shift = {rem, 1'b1};
  assign rem_ge    = rem_shift >= {1'b0, a_next};
  assign rem_diff  = rem_shift[DW-1:0] - a_next;

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      busy       <= 1'b0;
      frame_max  <= '0;
      a_next     <= '0;
      a_act      <= '0;
      omega_next <= '0;
      omega_act  <= '0;
      recip      <= '0;
      recip_act  <= '0;
      rem        <= '0;
      div_cnt    <= '0;
    end else begin
      vsync_q <= pix.i_vsync;
      if (frame_edge) begin
        // A boundary always restarts the division, even mid-DIV or in LOAD.
        frame_max  <= pix.i_de ? pix.i_dark : '0;
        a_next     <= a_cand;
        omega_next <= i_omega;
        rem        <= '0;
        recip      <= '0;
        div_cnt    <= CW'(RW - 1);
        state      <= DIV;
        busy       <= 1'b1;
      end else begin
        if (pix.i_de && (pix.i_dark > frame_max)) frame_max <= pix.i_dark;
        case (state)
          DIV: begin
            rem   <= rem_ge ? rem_diff : rem_shift[DW-1:0];
            recip <= {recip[RW-2:0], rem_ge};
            if (div_cnt == '0) state <= LOAD;
            else div_cnt <= div_cnt - 1'b1;
          end
          LOAD: begin
            a_act     <= a_next;
            recip_act <= recip;
            omega_act <= omega_next;
            state     <= IDLE;
            busy      <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [DW-1:0] s1_d;
  logic [PW-1:0] s2_p;
  logic [DW-1:0] s3_q;
  logic [DW-1:0] s4_t;
  logic [DW-1:0] s5_out;
  logic [4:0]    hs_sr;
  logic [4:0]    vs_sr;
  logic [4:0]    de_sr;
  logic [MW-1:0] prod;
  logic [MW-1:0] q_full;
  logic [DW-1:0] q_sat;

  assign prod   = MW'(s2_p) * MW'(recip_act);
  assign q_full = prod >> (8 + FRAC);
  assign q_sat  = (q_full > MW'(DMAX)) ? DMAX : q_full[DW-1:0];

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      s1_d   <= '0;
      s2_p   <= '0;
      s3_q   <= '0;
      s4_t   <= '0;
      s5_out <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
      de_sr  <= '0;
    end else begin
      s1_d   <= pix.i_dark;
      s2_p   <= PW'(s1_d) * PW'(omega_act);
      s3_q   <= q_sat;
      s4_t   <= DMAX - s3_q;
      s5_out <= de_sr[3] ? ((s4_t > i_thre) ? s4_t : i_thre) : '0;
      hs_sr  <= {hs_sr[3:0], pix.i_hsync};
      vs_sr  <= {vs_sr[3:0], pix.i_vsync};
      de_sr  <= {de_sr[3:0], pix.i_de};
    end
  end

  assign pix.o_transmittance = s5_out;
  assign pix.o_hsync         = hs_sr[4];
  assign pix.o_vsync         = vs_sr[4];
  assign pix.o_de            = de_sr[4];
  assign o_atmos             = a_act;
  assign o_recip_busy        = busy;
endmodule
